// File: rtl/sd_frame_ctrl.sv
// rtl/sd_frame_ctrl.sv - word-to-bit sequencer for the 1001 Moore detector
// Clears the detector, streams one word through it and reports match count/first index.
module sd_frame_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4,
  parameter bit MSB_FIRST = 1'b1,
  localparam int IDX_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             det_clr,
  output logic             det_din,
  input  logic             det_dout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] out_count,
  output logic             out_hit,
  output logic [IDX_W-1:0] out_first,
  output logic             busy
);

  typedef enum logic [2:0] {IDLE, CLEAR, SHIFT, DRAIN, DONE} state_t;

  state_t             state, next_state;
  logic [WIDTH-1:0]   shreg;
  logic [IDX_W-1:0]   idx;
  logic [CNT_W-1:0]   count;
  logic               found;
  logic [IDX_W-1:0]   first;
  logic               sample;
  logic               last_bit;

  assign last_bit = (idx == IDX_W'(WIDTH - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (in_valid) next_state = CLEAR;
      CLEAR:   next_state = SHIFT;
      SHIFT:   if (last_bit) next_state = DRAIN;
      DRAIN:   next_state = DONE;
      DONE:    if (out_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // det_dout lags det_din by one cycle, so the first SHIFT cycle carries no result.
  assign sample = ((state == SHIFT) && (idx != '0)) || (state == DRAIN);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shreg <= '0;
      idx   <= '0;
      count <= '0;
      found <= 1'b0;
      first <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            shreg <= in_data;
            count <= '0;
            found <= 1'b0;
            first <= '0;
          end
        end
        CLEAR: idx <= '0;
        SHIFT: begin
          shreg <= MSB_FIRST ? (shreg << 1) : (shreg >> 1);
          idx   <= idx + 1'b1;
        end
        default: ;
      endcase
      if (sample && det_dout) begin
        if (count != {CNT_W{1'b1}}) count <= count + 1'b1;
        if (!found) begin
          found <= 1'b1;
          first <= (state == DRAIN) ? IDX_W'(WIDTH - 1) : (idx - 1'b1);
        end
      end
    end
  end

  // Reset gates the handshake and holds the detector cleared combinationally.
  assign in_ready  = reset && (state == IDLE);
  assign det_clr   = !reset || (state == CLEAR);
  assign det_din   = (state == SHIFT) && (MSB_FIRST ? shreg[WIDTH-1] : shreg[0]);
  assign out_valid = (state == DONE);
  assign out_count = count;
  assign out_hit   = (count != '0);
  assign out_first = first;
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_sd_frame_ctrl.sv
// tb/tb_sd_frame_ctrl.sv - randomized bench with word-level reference model
// Three controllers (default, CNT_W=1, LSB-first), each driving a behavioural 1001 detector.
module tb_sd_frame_ctrl;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Main DUT
  logic       in_valid, in_ready, det_clr, det_din, det_dout, out_valid, out_ready, out_hit, busy;
  logic [7:0] in_data;
  logic [3:0] out_count;
  logic [2:0] out_first;
  logic [3:0] hist_a = '0;

  sd_frame_ctrl #(.WIDTH(8), .CNT_W(4), .MSB_FIRST(1'b1)) dut_a (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .det_clr(det_clr), .det_din(det_din), .det_dout(det_dout), .out_valid(out_valid),
    .out_ready(out_ready), .out_count(out_count), .out_hit(out_hit), .out_first(out_first), .busy(busy));

  // Saturating-counter variant
  logic       in_valid_b, in_ready_b, det_clr_b, det_din_b, det_dout_b, out_valid_b, out_hit_b, busy_b;
  logic [7:0] in_data_b;
  logic [0:0] out_count_b;
  logic [2:0] out_first_b;
  logic [3:0] hist_b = '0;

  sd_frame_ctrl #(.WIDTH(8), .CNT_W(1), .MSB_FIRST(1'b1)) dut_b (
    .clk(clk), .reset(reset), .in_valid(in_valid_b), .in_ready(in_ready_b), .in_data(in_data_b),
    .det_clr(det_clr_b), .det_din(det_din_b), .det_dout(det_dout_b), .out_valid(out_valid_b),
    .out_ready(1'b1), .out_count(out_count_b), .out_hit(out_hit_b), .out_first(out_first_b), .busy(busy_b));

  // LSB-first variant
  logic       in_valid_c, in_ready_c, det_clr_c, det_din_c, det_dout_c, out_valid_c, out_hit_c, busy_c;
  logic [7:0] in_data_c;
  logic [3:0] out_count_c;
  logic [2:0] out_first_c;
  logic [3:0] hist_c = '0;

  sd_frame_ctrl #(.WIDTH(8), .CNT_W(4), .MSB_FIRST(1'b0)) dut_c (
    .clk(clk), .reset(reset), .in_valid(in_valid_c), .in_ready(in_ready_c), .in_data(in_data_c),
    .det_clr(det_clr_c), .det_din(det_din_c), .det_dout(det_dout_c), .out_valid(out_valid_c),
    .out_ready(1'b1), .out_count(out_count_c), .out_hit(out_hit_c), .out_first(out_first_c), .busy(busy_c));

  // Behavioural Moore 1001 detectors: output is a function of the last four bits taken.
  always @(posedge clk) begin
    hist_a <= det_clr   ? 4'd0 : {hist_a[2:0], det_din};
    hist_b <= det_clr_b ? 4'd0 : {hist_b[2:0], det_din_b};
    hist_c <= det_clr_c ? 4'd0 : {hist_c[2:0], det_din_c};
  end
  assign det_dout   = (hist_a == 4'b1001);
  assign det_dout_b = (hist_b == 4'b1001);
  assign det_dout_c = (hist_c == 4'b1001);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic bit_at(input logic [7:0] d, input int i, input bit msb);
    return msb ? d[7-i] : d[i];
  endfunction

  // Word-level reference: scan the shift-order bit string for overlapping 1001 windows.
  function automatic void ref_word(input logic [7:0] d, input bit msb, input int cw,
                                   output int cnt, output int first);
    logic b [8];
    cnt = 0;
    first = 0;
    for (int i = 0; i < 8; i++) b[i] = bit_at(d, i, msb);
    for (int i = 3; i < 8; i++) begin
      if (b[i-3] && !b[i-2] && !b[i-1] && b[i]) begin
        if (cnt == 0) first = i;
        if (cnt < (1 << cw) - 1) cnt++;
      end
    end
  endfunction

  // Scoreboard state for the main DUT
  bit         pend = 0;
  bit         prev_ov = 0;
  int         due, acc_edge, exp_cnt, exp_first;
  logic [7:0] cur;
  int         done_cnt = 0;
  int         last_count, last_first, last_hit, last_lat;

  always @(negedge clk) begin
    bit exp_ov;
    if (cyc >= 2) begin
      if (!reset) begin
        chk("rst_in_ready", in_ready, 0);
        chk("rst_det_clr", det_clr, 1);
        chk("rst_det_din", det_din, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_count", out_count, 0);
        chk("rst_out_hit", out_hit, 0);
        chk("rst_out_first", out_first, 0);
        chk("rst_busy", busy, 0);
        pend = 0;
        prev_ov = 0;
      end else begin
        exp_ov = pend && (cyc >= due);
        chk("out_valid", out_valid, exp_ov);
        chk("in_ready", in_ready, !pend);
        chk("busy", busy, pend);
        chk("det_clr", det_clr, pend && (cyc == due - 10));
        chk("det_din", det_din,
            (pend && cyc >= due - 9 && cyc <= due - 2) ? bit_at(cur, cyc - (due - 9), 1'b1) : 1'b0);
        if (exp_ov) begin
          chk("out_count", out_count, exp_cnt);
          chk("out_hit", out_hit, exp_cnt != 0);
          chk("out_first", out_first, exp_first);
        end
        if (out_valid && !prev_ov) last_lat = cyc - acc_edge;
        prev_ov = out_valid;
        if (exp_ov && out_ready) begin
          pend = 0;
          last_count = out_count;
          last_first = out_first;
          last_hit = out_hit;
          done_cnt++;
        end else if (!pend && in_valid) begin
          pend = 1;
          cur = in_data;
          acc_edge = cyc + 1;
          due = cyc + 11;
          ref_word(in_data, 1'b1, 4, exp_cnt, exp_first);
        end
      end
    end
  end

  // out_ready driver: random or bench-controlled level
  bit rand_or = 0;
  bit or_val = 0;
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      out_ready = rand_or ? 1'($urandom_range(0, 1)) : or_val;
    end
  end

  task automatic send(input logic [7:0] d);
    int n = 0;
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_data = d;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("accept_wait", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data = 8'($urandom);
  endtask

  task automatic wait_done(input int target);
    int n = 0;
    while (done_cnt < target && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("done_wait", done_cnt >= target, 1);
  endtask

  initial begin
    int d0, c, f, n;
    logic [7:0] wb, wc;
    reset = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    in_valid_b = 1'b0;
    in_data_b = '0;
    in_valid_c = 1'b0;
    in_data_c = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_det_clr", det_clr, 0);

    ref_word(8'b1001_0010, 1'b1, 4, c, f);
    chk("model_overlap_cnt", c, 2);
    ref_word(8'b1001_1001, 1'b1, 1, c, f);
    chk("model_sat_cnt", c, 1);

    // Single match, latency, overlap, empty word
    or_val = 1;
    d0 = done_cnt;
    send(8'b1001_0000);
    wait_done(d0 + 1);
    chk("t1_count", last_count, 1);
    chk("t1_hit", last_hit, 1);
    chk("t1_first", last_first, 3);
    chk("t1_latency", last_lat, 10);
    send(8'b1001_0010);
    wait_done(d0 + 2);
    chk("t2_count", last_count, 2);
    chk("t2_first", last_first, 3);
    send(8'h00);
    wait_done(d0 + 3);
    chk("t2_zero_count", last_count, 0);
    chk("t2_zero_hit", last_hit, 0);
    chk("t2_zero_first", last_first, 0);

    // Consumer backpressure in DONE
    or_val = 0;
    d0 = done_cnt;
    send(8'b1001_0000);
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    repeat (5) begin
      @(negedge clk);
      chk("t3_hold_valid", out_valid, 1);
      chk("t3_hold_in_ready", in_ready, 0);
      chk("t3_hold_count", out_count, 1);
    end
    or_val = 1;
    wait_done(d0 + 1);
    send(8'b1001_0010);
    wait_done(d0 + 2);
    chk("t3_next_count", last_count, 2);

    // Back-to-back words must not match across the boundary
    d0 = done_cnt;
    send(8'b0000_0100);
    send(8'b1000_0000);
    chk("t4_first_word", last_count, 0);
    wait_done(d0 + 2);
    chk("t4_second_word", last_count, 0);

    // Reset during SHIFT bit 4 aborts the word
    d0 = done_cnt;
    send(8'b1001_0000);
    repeat (5) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("t5_det_clr", det_clr, 1);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("t5_in_ready", in_ready, 1);
    chk("t5_no_result", done_cnt, d0);
    send(8'b1001_0000);
    wait_done(d0 + 1);
    chk("t5_count", last_count, 1);

    // Random words with random gaps and backpressure
    rand_or = 1;
    d0 = done_cnt;
    for (int k = 0; k < 40; k++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      send((k % 4 == 0) ? 8'($urandom_range(0, 15) | 8'h90) : 8'($urandom));
    end
    rand_or = 0;
    or_val = 1;
    wait_done(d0 + 40);

    // Parameter variants: saturating CNT_W=1 and LSB-first
    for (int k = 0; k < 12; k++) begin
      wb = (k == 0) ? 8'b1001_1001 : 8'($urandom);
      wc = (k == 0) ? 8'b0000_1001 : 8'($urandom);
      @(posedge clk);
      #1;
      in_valid_b = 1'b1;
      in_data_b = wb;
      in_valid_c = 1'b1;
      in_data_c = wc;
      @(negedge clk);
      chk("v_ready_b", in_ready_b, 1);
      chk("v_ready_c", in_ready_c, 1);
      @(posedge clk);
      #1;
      in_valid_b = 1'b0;
      in_valid_c = 1'b0;
      n = 0;
      @(negedge clk);
      while (!out_valid_b && n < 30) begin
        @(negedge clk);
        n++;
      end
      chk("v_valid_b", out_valid_b, 1);
      chk("v_valid_c", out_valid_c, 1);
      ref_word(wb, 1'b1, 1, c, f);
      chk("v_count_b", out_count_b, c);
      chk("v_first_b", out_first_b, f);
      ref_word(wc, 1'b0, 4, c, f);
      chk("v_count_c", out_count_c, c);
      chk("v_first_c", out_first_c, f);
      chk("v_hit_c", out_hit_c, c != 0);
      if (k == 0) begin
        chk("t6_sat_count", out_count_b, 1);
        chk("t6_sat_first", out_first_b, 3);
        chk("t6_lsb_count", out_count_c, 1);
        chk("t6_lsb_first", out_first_c, 3);
      end
    end

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
